// File: rtl/decoder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// decoder_rr_arbiter
//   Eight-requester round-robin arbiter that presents its grant in 3-to-8
//   decoder form (sel + ena) plus the decoded one-hot grant vector. A grant
//   is held while the winner keeps requesting, up to HOLD_MAX cycles. Every
//   release passes through one IDLE cycle before the next grant.
//
// Parameters
//   HOLD_MAX : maximum consecutive cycles one grant is held (1..255)
//
// Ports
//   clk   : in  clock, all state updates on the rising edge
//   rst   : in  asynchronous, active-high reset
//   req   : in  [7:0] request lines, bit i belongs to requester i
//   sel   : out [2:0] index of the granted requester (decoder select)
//   ena   : out decoder enable, high only while a grant is active
//   grant : out [7:0] one-hot grant, zero whenever ena is low
//   busy  : out high while the FSM is in GRANT
// -----------------------------------------------------------------------------
module decoder_rr_arbiter #(
   parameter int HOLD_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [2:0] sel,
   output logic       ena,
   output logic [7:0] grant,
   output logic       busy
);

   localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t     state_r;
   logic [2:0] sel_r;
   logic [2:0] ptr_r;
   logic [7:0] cnt_r;
   logic       ena_r;
   logic       busy_r;
   logic [7:0] grant_r;

   logic [2:0] winner_s;
   logic       release_s;

   // First set request bit searching upward from p+1, wrapping 7->0; the
   // last candidate examined is p itself, giving it lowest priority.
   function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
      logic [2:0] idx;
      logic       found;
      rr_pick = p;
      found   = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         idx = p + 3'(k);
         if (!found && r[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   // Round-robin winner for the current request vector and pointer.
   always_comb begin
      winner_s = rr_pick(req, ptr_r);
   end

   // Release condition: granted requester dropped, or hold limit reached.
   always_comb begin
      release_s = 1'b0;
      if ((req[sel_r] == 1'b0) || (cnt_r == HOLD_MAX_C)) begin
         release_s = 1'b1;
      end else begin
         release_s = 1'b0;
      end
   end

   // Arbiter FSM with registered decoder outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         sel_r   <= 3'd0;
         ptr_r   <= 3'd7;
         cnt_r   <= 8'd0;
         ena_r   <= 1'b0;
         busy_r  <= 1'b0;
         grant_r <= 8'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req != 8'd0) begin
                  state_r <= ST_GRANT;
                  sel_r   <= winner_s;
                  cnt_r   <= 8'd1;
                  ena_r   <= 1'b1;
                  busy_r  <= 1'b1;
                  grant_r <= 8'd1 << winner_s;
               end
            end
            ST_GRANT: begin
               // Release wins over any new request at the same edge; the
               // next arbitration happens in the following IDLE cycle.
               if (release_s) begin
                  state_r <= ST_IDLE;
                  ptr_r   <= sel_r;
                  ena_r   <= 1'b0;
                  busy_r  <= 1'b0;
                  grant_r <= 8'd0;
               end else begin
                  cnt_r   <= cnt_r + 8'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               ena_r   <= 1'b0;
               busy_r  <= 1'b0;
               grant_r <= 8'd0;
            end
         endcase
      end
   end

   assign sel   = sel_r;
   assign ena   = ena_r;
   assign busy  = busy_r;
   assign grant = grant_r;

endmodule

// File: doc/decoder_rr_arbiter.md
DECODER_RR_ARBITER -- requirements
Module: decoder_rr_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 15, giving the maximum consecutive cycles one grant is held; legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port req, input, 8, with one request line per requester, where bit i is requester i.
REQ-005 The block SHALL have port sel, output, 3: the index of the granted requester, in the 3-to-8 decoder select format.
REQ-006 The block SHALL have port ena, output, 1: the decoder enable, high only while a grant is active.
REQ-007 The block SHALL have port grant, output, 8: the one-hot grant; it is 8'd0 whenever ena is low, else 8'd1 shifted left by sel.
REQ-008 The block SHALL have port busy, output, 1, which is high in GRANT state.
REQ-009 All outputs SHALL be registered, or decoded only from registered state; there is no combinational path from req to any output.

Function
REQ-010 The FSM SHALL have two states: IDLE (ena=0) and GRANT (ena=1, busy=1).
REQ-011 The block SHALL keep a 3-bit priority pointer ptr that holds the index of the last granted requester.
REQ-012 In IDLE with req nonzero, the winner SHALL be the first set bit of req, searched from index ptr+1 upward mod 8 with wrap-around 7->0; the winner is the lowest-priority position when it equals ptr.
REQ-013 Arbitration latency: when req is sampled nonzero in IDLE at edge N, then sel=winner and ena=1 from edge N, and the FSM enters GRANT.
REQ-014 In IDLE with req=0, the FSM SHALL stay in IDLE, and sel and ptr SHALL hold their values.
REQ-015 On GRANT entry, the hold counter cnt (8-bit) SHALL load 1; each further GRANT cycle without release SHALL increment it.
REQ-016 In GRANT, the block SHALL release at an edge where req[sel]=0 or cnt==HOLD_MAX; on release, ptr<=sel, ena<=0, and the FSM enters IDLE.
REQ-017 Release SHALL always pass through one IDLE cycle, so a gap of at least one ena=0 cycle separates consecutive grants, including re-grant to the same requester.
REQ-018 A grant SHALL last at most HOLD_MAX cycles; with HOLD_MAX=1 every grant is exactly one cycle.
REQ-019 Changes to req bits other than req[sel] during GRANT SHALL NOT affect sel, ena or cnt.
REQ-020 When release and a new request coincide at the same edge, the FSM SHALL perform release only; the new request is arbitrated in the following IDLE cycle using the updated ptr.
REQ-021 sel SHALL remain stable for the entire GRANT interval.

Reset
REQ-022 With rst high, the block SHALL asynchronously force state=IDLE, sel=3'd0, ena=0, grant=8'd0, busy=0, cnt=0 and ptr=3'd7, so that requester 0 has first priority.
REQ-023 Asserting rst mid-GRANT SHALL drop ena and grant in the same cycle with no wait for a clock edge.
REQ-024 The first arbitration after rst deasserts SHALL use ptr=7.

Verification
REQ-025 Reset, then req=8'b1000_0001 held -> grant=8'h01 for 15 cycles, one idle cycle, grant=8'h80 for 15 cycles, one idle cycle, then grant=8'h01 again.
REQ-026 Reset, then req=8'h04 for 3 cycles, then req=0 -> sel=2, ena=1 for exactly 3 cycles, then ena=0; the next req=8'h05 is granted to requester 0 (sel=0), since the search starts at index 3 and wraps.
REQ-027 Reset, then req=8'hFF held with HOLD_MAX=1 -> sel sequence 0,1,2,...,7,0 with ena alternating 1,0.
REQ-028 Mid-grant to requester 3, toggle req[5] and req[1] -> sel stays 3 and cnt is unaffected; after release, ptr=3 and the next grant goes to 5.
REQ-029 Assert rst asynchronously between clock edges during GRANT -> ena=0 and grant=0 immediately; after rst deasserts with req=8'h80, the next grant goes to sel=7.
REQ-030 At every cycle, the bench SHALL check that grant equals the decoder of (sel, ena) and that grant is one-hot or zero.
